addsub_seq: RTL
===============

# addsub_seq

Parametrised, multi-cycle two's-complement adder/subtractor. It processes operands LSB-first, DIGIT bits per clock, and holds a registered carry between chunks. It is the sequential, width-generic successor to the team's 8-bit combinational ripple add/sub. It adds a start/done handshake and zero and negative flags, and it sits in the datapath wherever an area-cheap ALU add/sub is acceptable at the cost of latency.

## Interface
- WIDTH, 8, operand/result width; must be ≥ 2.
- DIGIT, 2, bits processed per clock; 1 ≤ DIGIT ≤ WIDTH, WIDTH % DIGIT == 0.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request; sampled on rising edge.
- s  in  1  mode: 0 = a+b, 1 = a−b; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while a computation is in progress.
- done  out  1  one-cycle pulse; result and flags valid and updated.
- out  out  WIDTH  result, modulo 2^WIDTH.
- c  out  1  carry out of MSB; for subtraction 1 = no borrow.
- v  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- z  out  1  out == 0.
- n  out  1  out[WIDTH-1].

## Operation
- NCHUNK = WIDTH/DIGIT. Internal state:
  - shift registers for A and B^{s} (B inverted when s=1);
  - carry register;
  - chunk counter, width ceil(log2(NCHUNK+1));
  - result shift register.
- States: IDLE, RUN, DONE.
- IDLE: start=1 → load a, b XOR {WIDTH{s}}; carry ← s; counter ← 0; go RUN. start=0 → stay.
- RUN: each cycle, add the low DIGIT bits of both operand registers plus carry.
  - Shift the sum into the result register from the top.
  - Carry ← chunk carry-out; shift operands right by DIGIT; counter+1.
  - On the last chunk (counter == NCHUNK−1):
    - c ← chunk carry-out;
    - v ← carry into bit WIDTH−1 XOR carry-out;
    - out ← full result; z, n from the full result;
    - go DONE.
- DONE: done=1 for this cycle only.
  - start=1 → accept new operands exactly as from IDLE and go RUN (back-to-back).
  - Otherwise go IDLE.
- start while in RUN is ignored; there is no queueing.
- out, c, v, z, n change only at completion of a computation. They hold their values through IDLE and through the next RUN.
- Width rule: all arithmetic is modulo 2^WIDTH.
- Subtraction is A + ~B + 1. This yields c=1 when a ≥ b unsigned.

## Timing
- Reset (rst_n=0, any time, including mid-RUN):
  - state IDLE; busy=0, done=0;
  - out=0, c=0, v=0, z=0, n=0;
  - counter, carry and shift registers cleared.
- A computation in progress at reset is discarded. The first start is accepted on the first rising edge with rst_n=1.
- start accepted at edge E0 → busy=1 after E0. RUN occupies edges E1..E_NCHUNK.
- Results, flags, done=1 and busy=0 all become visible after edge E_NCHUNK, simultaneously. Latency = NCHUNK cycles start-to-done.
- Back-to-back: start=1 while done=1 → busy returns to 1 on the next edge. Throughput is one result per NCHUNK+1 cycles.
- DIGIT=WIDTH: NCHUNK=1, so done follows the start edge by exactly one cycle.

## Test plan
- WIDTH=8, DIGIT=2: a=0x7F, b=0x01, s=0 → after 4 cycles done pulse. Required: out=0x80, c=0, v=1, z=0, n=1; busy high for exactly 4 cycles.
- a=0x05, b=0x05, s=1 → out=0x00, c=1, v=0, z=1, n=0. Then a=0x80, b=0x01, s=1 → out=0x7F, c=1, v=1, z=0, n=0.
- a=0xFF, b=0x01, s=0, with start held high through DONE and a new operand pair 0x03−0x05 → first result out=0x00, c=1, z=1. Second start is accepted in the DONE cycle; second result out=0xFE, c=0, v=0, n=1.
- Assert start with different operands on every RUN cycle → ignored. Result matches only the accepted operands; exactly one done pulse.
- Drop rst_n after 2 RUN cycles → all outputs 0 immediately. A start after release computes correctly: 0x10+0x20 → out=0x30.
- Sweep WIDTH=16, DIGIT ∈ {1,4,16} with random operands against a+b / a−b reference model. Check out, c, v, z, n, and latency = 16/DIGIT.

Source files
------------

// File: rtl/addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : addsub_seq
// Purpose  : Multi-cycle two's-complement adder/subtractor. Operands are
//            consumed LSB-first, DIGIT bits per clock, with a registered
//            carry between chunks. Start/done handshake with C/V/Z/N flags.
// Revision : 1.0 - initial release
// ============================================================================
module addsub_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             c,
  output logic             v,
  output logic             z,
  output logic             n
);

  localparam int NCHUNK = WIDTH / DIGIT;
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   chunk_sum;
  logic             chunk_cout;
  logic             msb_cin;
  logic             accept;
  logic             last_chunk;

  // Chunk adder: low DIGIT bits of both operands plus the running carry
  always_comb begin
    chunk_sum  = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, carry};
    chunk_cout = chunk_sum[DIGIT];
    // Carry into the chunk's top bit recovered from its sum bit; on the
    // final chunk this is the carry into the operand MSB.
    msb_cin    = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ chunk_sum[DIGIT-1];
    accept     = start && ((state == IDLE) || (state == DONE));
    last_chunk = (cnt == LAST_CHUNK);
  end

  // New sum bits enter the result register from the top
  generate
    if (DIGIT == WIDTH) begin : g_single_chunk
      assign res_next = chunk_sum[DIGIT-1:0];
    end else begin : g_multi_chunk
      assign res_next = {chunk_sum[DIGIT-1:0], res_sh[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Sequencer and serial datapath: load on accept, step one chunk per cycle in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          res_sh <= res_next;
          carry  <= chunk_cout;
          cnt    <= cnt + CW'(1);
          if (last_chunk) begin
            state <= DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a request; subtraction is a + ~b + 1
          if (accept) begin
            a_sh   <= a;
            b_sh   <= b ^ {WIDTH{s}};
            carry  <= s;
            cnt    <= '0;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
      endcase
    end
  end

  // Visible result and flags update only when the last chunk completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
      c   <= 1'b0;
      v   <= 1'b0;
      z   <= 1'b0;
      n   <= 1'b0;
    end else if ((state == RUN) && last_chunk) begin
      out <= res_next;
      c   <= chunk_cout;
      v   <= msb_cin ^ chunk_cout;
      z   <= (res_next == '0);
      n   <= res_next[WIDTH-1];
    end
  end

endmodule
`default_nettype wire
